// File: rtl/piso_tx_sched_pkg.sv
// Shared definitions for the PISO transmit scheduler: state encoding and
// width helpers used by the scheduler and its round-robin arbiter.
package piso_tx_sched_pkg;

  // Frame sequencing states, kept as plain constants so older tools and
  // waveform viewers see stable numeric encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // The inter-frame gap counter is fixed at 4 bits (gap of 0..15 cycles).
  localparam int GAP_CNT_W = 4;

  // clog2 that never returns 0, so counters and indices are at least 1 bit wide.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/piso_tx_sched_rr_arbiter.sv
// Purely combinational round-robin arbiter: picks the first valid requester
// starting at ptr and wrapping at NUM_REQ-1 -> 0. Pointer storage lives in the
// scheduler; this block only searches.
module rr_arbiter
  import piso_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PW = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      grant_idx,
  output logic               any_grant
);

  // Walk the requesters in priority order from ptr and lock onto the first valid one.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any_grant && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin scheduler sharing one LSB-first PISO serializer between
// NUM_REQ requesters. Accepts one word per frame, drives load then N shift
// cycles, optionally idles GAP cycles, and emits framing strobes aligned to
// the serializer's registered s_data output.
module piso_tx_sched
  import piso_tx_sched_pkg::*;
#(
  parameter int N       = 8,
  parameter int NUM_REQ = 4,
  parameter int GAP     = 0,
  localparam int CW = clog2_min1(N),
  localparam int PW = clog2_min1(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*N-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 piso_load,
  output logic                 piso_shift_en,
  output logic [N-1:0]         piso_data,
  output logic [PW-1:0]        grant_id,
  output logic                 ser_valid,
  output logic                 ser_last,
  output logic                 busy
);

  localparam logic [CW-1:0]        BIT_LAST = CW'(N - 1);
  localparam logic [PW-1:0]        PTR_LAST = PW'(NUM_REQ - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic                 piso_load_q, piso_load_d;
  logic                 piso_shift_en_q, piso_shift_en_d;
  logic [N-1:0]         piso_data_q, piso_data_d;
  logic [PW-1:0]        grant_id_q, grant_id_d;
  logic                 ser_valid_q, ser_valid_d;
  logic                 ser_last_q, ser_last_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [PW-1:0]        arb_idx;
  logic                 arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  // Ready is only offered in IDLE and is suppressed entirely while reset is held.
  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == ST_IDLE)) begin
      req_ready = arb_grant;
    end
  end

  // Next-state, counters, word capture, and strobes derived from the next state.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    piso_data_d = piso_data_q;
    grant_id_d  = grant_id_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d     = ST_LOAD;
          piso_data_d = req_data[int'(arb_idx)*N +: N];
          grant_id_d  = arb_idx;
          ptr_d       = (arb_idx == PTR_LAST) ? '0 : arb_idx + 1'b1;
        end
      end
      ST_LOAD: begin
        state_d   = ST_SHIFT;
        bit_cnt_d = '0;
      end
      ST_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    piso_load_d     = (state_d == ST_LOAD);
    piso_shift_en_d = (state_d == ST_SHIFT);
    ser_valid_d     = piso_shift_en_q;
    ser_last_d      = piso_shift_en_q && (bit_cnt_q == BIT_LAST);
  end

  // State and output registers with synchronous reset that aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      bit_cnt_q       <= '0;
      gap_cnt_q       <= '0;
      piso_load_q     <= 1'b0;
      piso_shift_en_q <= 1'b0;
      piso_data_q     <= '0;
      grant_id_q      <= '0;
      ser_valid_q     <= 1'b0;
      ser_last_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      bit_cnt_q       <= bit_cnt_d;
      gap_cnt_q       <= gap_cnt_d;
      piso_load_q     <= piso_load_d;
      piso_shift_en_q <= piso_shift_en_d;
      piso_data_q     <= piso_data_d;
      grant_id_q      <= grant_id_d;
      ser_valid_q     <= ser_valid_d;
      ser_last_q      <= ser_last_d;
    end
  end

  assign piso_load     = piso_load_q;
  assign piso_shift_en = piso_shift_en_q;
  assign piso_data     = piso_data_q;
  assign grant_id      = grant_id_q;
  assign ser_valid     = ser_valid_q;
  assign ser_last      = ser_last_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_tx_sched.sv
// Directed bench for piso_tx_sched: a GAP=0 instance with a reference PISO
// attached and a GAP=3 instance sharing the same requester inputs.
module tb_piso_tx_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;

   logic [3:0]  req_ready;
   logic        piso_load, piso_shift_en, ser_valid, ser_last, busy;
   logic [7:0]  piso_data;
   logic [1:0]  grant_id;

   logic [3:0]  req_ready_g;
   logic        piso_load_g, piso_shift_en_g, ser_valid_g, ser_last_g, busy_g;
   logic [7:0]  piso_data_g;
   logic [1:0]  grant_id_g;

   int assertCount = 0;
   int failCount = 0;
   int cycleCount = 0;

   logic [7:0] modelReg = '0;
   logic       modelSData = 1'b0;

   piso_tx_sched #(.N(8), .NUM_REQ(4), .GAP(0)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .piso_load(piso_load), .piso_shift_en(piso_shift_en),
      .piso_data(piso_data), .grant_id(grant_id), .ser_valid(ser_valid),
      .ser_last(ser_last), .busy(busy)
   );

   piso_tx_sched #(.N(8), .NUM_REQ(4), .GAP(3)) dutGap (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready_g), .piso_load(piso_load_g), .piso_shift_en(piso_shift_en_g),
      .piso_data(piso_data_g), .grant_id(grant_id_g), .ser_valid(ser_valid_g),
      .ser_last(ser_last_g), .busy(busy_g)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Cycle counter used to measure accept-to-accept spacing.
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Reference LSB-first PISO with a registered serial output.
   always @(posedge clk) begin
      if (piso_load) begin
         modelReg <= piso_data;
      end else if (piso_shift_en) begin
         modelSData <= modelReg[0];
         modelReg <= modelReg >> 1;
      end
   end

   // Hard stop in case something stalls the stimulus thread.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
      req_valid = valid;
      req_data = data;
      #1;
   endtask

   task automatic resetDut();
      rst = 1'b1;
      applyStimulus(4'b1111, 32'h44332211);
      checkOutput("rst_ready_forced", {28'd0, req_ready}, 32'd0);
      tick();
      checkOutput("rst_load", {31'd0, piso_load}, 32'd0);
      checkOutput("rst_shift", {31'd0, piso_shift_en}, 32'd0);
      checkOutput("rst_data", {24'd0, piso_data}, 32'd0);
      checkOutput("rst_grant", {30'd0, grant_id}, 32'd0);
      checkOutput("rst_ser", {30'd0, ser_valid, ser_last}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_ready_held", {28'd0, req_ready}, 32'd0);
      rst = 1'b0;
      applyStimulus(4'b0000, 32'd0);
   endtask

   task automatic waitAccept(input bit useGap, input int budget, output logic [3:0] rdy, output int when);
      bit found = 1'b0;
      logic [3:0] cur;
      rdy = '0;
      when = 0;
      for (int n = 0; n < budget && !found; n++) begin
         cur = useGap ? req_ready_g : req_ready;
         if (cur != 4'd0) begin
            found = 1'b1;
            rdy = cur;
            when = cycleCount;
         end else begin
            tick();
         end
      end
      if (!found) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [3:0] rdy;
      int t0, t1, prevT;
      int loadSeen, readySeen;
      int s1Bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      logic [3:0] s2OneHot[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      logic [7:0] s2Data[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

      tick();

      // Scenario 1: single request from requester 0 carrying 0xA5.
      resetDut();
      applyStimulus(4'b0001, 32'hDEADBEA5);
      checkOutput("s1_ready", {28'd0, req_ready}, 32'd1);
      checkOutput("s1_idle_busy", {31'd0, busy}, 32'd0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) begin
            applyStimulus(4'b0000, 32'hDEADBEA5);
            checkOutput("s1_data", {24'd0, piso_data}, 32'hA5);
         end
         checkOutput("s1_load", {31'd0, piso_load}, (k == 1) ? 32'd1 : 32'd0);
         checkOutput("s1_shift", {31'd0, piso_shift_en}, (k >= 2 && k <= 9) ? 32'd1 : 32'd0);
         checkOutput("s1_ser_valid", {31'd0, ser_valid}, (k >= 3) ? 32'd1 : 32'd0);
         checkOutput("s1_ser_last", {31'd0, ser_last}, (k == 10) ? 32'd1 : 32'd0);
         checkOutput("s1_busy", {31'd0, busy}, (k <= 9) ? 32'd1 : 32'd0);
         if (k >= 3) checkOutput("s1_sdata", {31'd0, modelSData}, 32'(s1Bits[k-3]));
      end

      // Scenario 2: all requesters valid, grants rotate 0,1,2,3,0,1 ten cycles apart.
      resetDut();
      applyStimulus(4'b1111, 32'h44332211);
      prevT = 0;
      for (int i = 0; i < 6; i++) begin
         waitAccept(1'b0, 20, rdy, t0);
         checkOutput("s2_ready", {28'd0, rdy}, {28'd0, s2OneHot[i%4]});
         if (i > 0) checkOutput("s2_period", 32'(t0 - prevT), 32'd10);
         prevT = t0;
         tick();
         checkOutput("s2_grant", {30'd0, grant_id}, 32'(i % 4));
         checkOutput("s2_data", {24'd0, piso_data}, {24'd0, s2Data[i%4]});
      end

      // Scenario 3: requester 2 alone, then requester 0 joins mid-frame and wins next.
      resetDut();
      applyStimulus(4'b0100, 32'h00C30000);
      waitAccept(1'b0, 5, rdy, t0);
      checkOutput("s3_first", {28'd0, rdy}, 32'b0100);
      tick();
      applyStimulus(4'b0101, 32'h00C3005E);
      for (int k = 0; k < 9; k++) begin
         checkOutput("s3_ready_busy", {28'd0, req_ready}, 32'd0);
         tick();
      end
      waitAccept(1'b0, 5, rdy, t1);
      checkOutput("s3_second", {28'd0, rdy}, 32'b0001);
      checkOutput("s3_period", 32'(t1 - t0), 32'd10);
      tick();
      checkOutput("s3_data", {24'd0, piso_data}, 32'h5E);

      // Scenario 4: GAP=3 instance with requester 1 continuously valid.
      resetDut();
      applyStimulus(4'b0010, 32'h00003C00);
      waitAccept(1'b1, 5, rdy, t0);
      checkOutput("s4_first", {28'd0, rdy}, 32'b0010);
      for (int k = 1; k <= 13; k++) begin
         tick();
         if (k == 1) checkOutput("s4_grant", {30'd0, grant_id_g}, 32'd1);
         checkOutput("s4_load", {31'd0, piso_load_g}, (k == 1) ? 32'd1 : 32'd0);
         checkOutput("s4_shift", {31'd0, piso_shift_en_g}, (k >= 2 && k <= 9) ? 32'd1 : 32'd0);
         checkOutput("s4_ser_valid", {31'd0, ser_valid_g}, (k >= 3 && k <= 10) ? 32'd1 : 32'd0);
         checkOutput("s4_ser_last", {31'd0, ser_last_g}, (k == 10) ? 32'd1 : 32'd0);
         checkOutput("s4_busy", {31'd0, busy_g}, (k <= 12) ? 32'd1 : 32'd0);
         checkOutput("s4_ready", {28'd0, req_ready_g}, (k == 13) ? 32'b0010 : 32'd0);
      end
      waitAccept(1'b1, 5, rdy, t1);
      checkOutput("s4_period", 32'(t1 - t0), 32'd13);

      // Scenario 5: reset on the 4th shift cycle aborts the frame; grant restarts at 0.
      resetDut();
      applyStimulus(4'b0100, 32'h00A50077);
      waitAccept(1'b0, 5, rdy, t0);
      checkOutput("s5_first", {28'd0, rdy}, 32'b0100);
      for (int k = 1; k <= 5; k++) tick();
      checkOutput("s5_shifting", {31'd0, piso_shift_en}, 32'd1);
      rst = 1'b1;
      applyStimulus(4'b1111, 32'h00A50077);
      checkOutput("s5_ready_in_rst", {28'd0, req_ready}, 32'd0);
      tick();
      checkOutput("s5_load", {31'd0, piso_load}, 32'd0);
      checkOutput("s5_shift", {31'd0, piso_shift_en}, 32'd0);
      checkOutput("s5_data", {24'd0, piso_data}, 32'd0);
      checkOutput("s5_grant", {30'd0, grant_id}, 32'd0);
      checkOutput("s5_ser_valid", {31'd0, ser_valid}, 32'd0);
      checkOutput("s5_ser_last", {31'd0, ser_last}, 32'd0);
      checkOutput("s5_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("s5_ready_after", {28'd0, req_ready}, 32'b0001);
      tick();
      checkOutput("s5_grant_after", {30'd0, grant_id}, 32'd0);
      checkOutput("s5_data_after", {24'd0, piso_data}, 32'h77);
      checkOutput("s5_load_after", {31'd0, piso_load}, 32'd1);

      // Scenario 6: a one-cycle valid pulse during a frame must not start another frame.
      resetDut();
      applyStimulus(4'b0001, 32'h0000003C);
      waitAccept(1'b0, 5, rdy, t0);
      checkOutput("s6_first", {28'd0, rdy}, 32'b0001);
      tick();
      applyStimulus(4'b0000, 32'h0000003C);
      for (int k = 0; k < 3; k++) tick();
      applyStimulus(4'b1000, 32'h9900003C);
      checkOutput("s6_pulse_ready", {28'd0, req_ready}, 32'd0);
      tick();
      applyStimulus(4'b0000, 32'h9900003C);
      loadSeen = 0;
      readySeen = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (piso_load) loadSeen++;
         if (req_ready != 4'd0) readySeen++;
      end
      checkOutput("s6_no_load", 32'(loadSeen), 32'd0);
      checkOutput("s6_no_ready", 32'(readySeen), 32'd0);
      checkOutput("s6_idle", {31'd0, busy}, 32'd0);
      checkOutput("s6_data_held", {24'd0, piso_data}, 32'h3C);
      checkOutput("s6_grant_held", {30'd0, grant_id}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/piso_tx_sched.md
Name: piso_tx_sched

Overview:
Round-robin scheduler that shares one PISO serializer (N-bit, LSB-first, right-shift) between NUM_REQ parallel-word requesters. It accepts one word per frame through a valid/ready handshake, then drives the serializer's load and shift_en sequence. It also produces framing strobes aligned to the serializer's registered s_data output. It sits between the requester blocks and the PISO instance in the TX path.

Parameters:
N, 8, serializer word width in bits (≥2)
NUM_REQ, 4, number of requesters (≥2)
GAP, 0, idle cycles inserted after each frame (0..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester word available
req_data  in  NUM_REQ*N  flattened words; requester i occupies bits [i*N +: N]
req_ready  out  NUM_REQ  one-hot accept; at most one bit high
piso_load  out  1  drives PISO load
piso_shift_en  out  1  drives PISO shift_en
piso_data  out  N  drives PISO p_data
grant_id  out  clog2(NUM_REQ)  requester that owns the current frame
ser_valid  out  1  PISO s_data holds a frame bit this cycle
ser_last  out  1  PISO s_data holds the final (MSB) bit
busy  out  1  frame in progress (state ≠ IDLE)

Behaviour:
- States: IDLE, LOAD, SHIFT, GAP.
- Reset, applied on a clock edge while rst=1:
  - state=IDLE, rr pointer=0 (requester 0 has highest priority).
  - All registered outputs = 0: piso_load, piso_shift_en, piso_data, grant_id, ser_valid, ser_last, bit_cnt.
  - req_ready is forced 0 while rst=1.
  - Reset mid-frame aborts the frame without completion; the word is lost and no ser_last is issued.
- IDLE:
  - req_ready is combinational and one-hot for the round-robin winner among req_valid.
  - The search starts at pointer; the order is pointer, pointer+1, … with wrap at NUM_REQ-1→0.
  - On accept: capture req_data slice into piso_data, set grant_id, pointer←winner+1 (mod NUM_REQ), go to LOAD.
  - With no valid request: stay in IDLE with all req_ready=0.
- LOAD (1 cycle): piso_load=1 with piso_data stable; go to SHIFT with bit_cnt=0.
- SHIFT (N cycles):
  - piso_shift_en=1 each cycle; bit_cnt increments.
  - On bit_cnt=N-1: go to GAP if GAP>0, else IDLE.
- GAP (GAP cycles): all strobes 0; then go to IDLE.
- Mutual exclusion: piso_load and piso_shift_en are never high together. Neither is high in IDLE or GAP.
- Output alignment:
  - ser_valid = piso_shift_en delayed one cycle, matching PISO s_data registration.
  - ser_last = the delayed strobe of shift cycle bit_cnt=N-1.
- Handshake rules:
  - req_ready=0 in every state except IDLE; requests raised during a frame wait.
  - A requester may deassert valid at any time before being granted; no data is taken without ready&valid.
  - piso_data holds its value from accept until the next accept or reset.
- Latency and throughput:
  - Accept→piso_load: 1 cycle. Accept→first ser_valid: 3 cycles.
  - Minimum accept-to-accept period: N+2+GAP cycles.
- Width rules: bit_cnt is clog2(N) bits; gap_cnt is 4 bits; pointer is clog2(NUM_REQ) bits with explicit wrap when NUM_REQ is not a power of two.

Decomposition:
- Shared package: state encoding (IDLE=0, LOAD=1, SHIFT=2, GAP=3) and width-derivation constants (clog2 of N and NUM_REQ).
- One sub-module, rr_arbiter: a purely combinational one-hot winner from the valid vector plus pointer. Pointer storage and update stay in piso_tx_sched.

Test Plan:
All scenarios use N=8, NUM_REQ=4, GAP=0 unless stated, with a reference PISO model attached.
1. Single request: req_valid=0001, req_data[7:0]=0xA5.
   - req_ready=0001 in the same cycle; next cycle piso_load=1 with piso_data=0xA5.
   - 8 piso_shift_en cycles follow; ser_valid bits are 1,0,1,0,0,1,0,1; ser_last on the 8th bit; busy low afterwards.
2. All four requesters valid continuously: grant_id sequence 0,1,2,3,0,1; each accept 10 cycles apart.
3. Only requester 2 valid, then requester 0 raised mid-frame:
   - req_ready stays 0 during the frame.
   - The next IDLE grants 3→no, pointer=3 wraps, so 0 wins.
4. GAP=3 with requester 1 continuously valid: accepts are 13 cycles apart; 3 cycles of zero strobes after each ser_last.
5. rst asserted on the 4th shift cycle:
   - Next edge: all outputs 0, state IDLE, no ser_last.
   - After release with req_valid=1111: grant goes to 0.
6. req_valid pulsed for one cycle while busy, then dropped: no accept and no frame generated.
